// File: rtl/butterfly_pipe.sv
// butterfly_pipe: two-stage pipelined radix-2 DIT butterfly, out = (in_1 +/- W8^k*in_2) >> scale.
// Define BUTTERFLY_PIPE_SAT_EN to saturate results and enable the sticky ovf flag; otherwise results wrap.
module butterfly_pipe #(
  parameter  int N     = 3,
  parameter  int RECIP = 181,
  localparam int W     = 2**N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   tw_k,
  input  logic         scale,
  input  logic [W-1:0] in_1_r,
  input  logic [W-1:0] in_1_i,
  input  logic [W-1:0] in_2_r,
  input  logic [W-1:0] in_2_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_1_r,
  output logic [W-1:0] out_1_i,
  output logic [W-1:0] out_2_r,
  output logic [W-1:0] out_2_i,
  output logic         ovf,
  input  logic         ovf_clr
);

  localparam int MAX_I = 2**(W-1) - 1;
  localparam int MIN_I = -(2**(W-1));
  localparam logic signed [W+1:0] MAX_V   = (W+2)'(MAX_I);
  localparam logic signed [W+1:0] MIN_V   = (W+2)'(MIN_I);
  localparam logic signed [10:0]  RECIP_S = 11'(RECIP);

  // Operands arrive pre-widened so the negated sum -(a+b) = 2^W is represented exactly.
  function automatic logic signed [W:0] rmul(input logic signed [W+1:0] x);
    logic signed [W+12:0] p;
    p = (W+13)'(x) * (W+13)'(RECIP_S);
    return (W+1)'(p >>> 8);
  endfunction

  logic                s1_valid_q, s1_valid_d;
  logic                s1_scale_q, s1_scale_d;
  logic [W-1:0]        s1_in1r_q, s1_in1r_d;
  logic [W-1:0]        s1_in1i_q, s1_in1i_d;
  logic signed [W:0]   s1_tr_q, s1_tr_d;
  logic signed [W:0]   s1_ti_q, s1_ti_d;
  logic                s2_valid_q, s2_valid_d;
  logic [W-1:0]        s2_q [4];
  logic [W-1:0]        s2_d [4];

  logic                s2_load, s2_upd, in_fire;
  logic signed [W+1:0] a_x, b_x, sum_x, dif_x;
  logic signed [W:0]   tr_new, ti_new;
  logic signed [W+1:0] op_a [4];
  logic signed [W+1:0] op_t [4];
  logic signed [W+1:0] wide [4];
  logic [3:0]          oor;

  // Twiddle multiply on the incoming operand
  always_comb begin
    a_x   = (W+2)'($signed(in_2_r));
    b_x   = (W+2)'($signed(in_2_i));
    sum_x = a_x + b_x;
    dif_x = b_x - a_x;
    tr_new = '0;
    ti_new = '0;
    unique case (tw_k)
      2'd0: begin
        tr_new = (W+1)'(a_x);
        ti_new = (W+1)'(b_x);
      end
      2'd1: begin
        tr_new = rmul(sum_x);
        ti_new = rmul(dif_x);
      end
      2'd2: begin
        tr_new = (W+1)'(b_x);
        ti_new = (W+1)'(-a_x);
      end
      default: begin
        tr_new = rmul(dif_x);
        ti_new = rmul(-sum_x);
      end
    endcase
  end

  // Handshake and stage-1 next state
  always_comb begin
    s2_load    = !s2_valid_q || out_ready;
    in_ready   = !rst && (!s1_valid_q || s2_load);
    in_fire    = in_valid && in_ready;
    s2_upd     = s2_load && s1_valid_q;
    s1_valid_d = in_fire ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    s1_scale_d = s1_scale_q;
    s1_in1r_d  = s1_in1r_q;
    s1_in1i_d  = s1_in1i_q;
    s1_tr_d    = s1_tr_q;
    s1_ti_d    = s1_ti_q;
    if (in_fire) begin
      s1_scale_d = scale;
      s1_in1r_d  = in_1_r;
      s1_in1i_d  = in_1_i;
      s1_tr_d    = tr_new;
      s1_ti_d    = ti_new;
    end
  end

  // Add/subtract, scale and W-bit reduction into the output register
  always_comb begin
    op_a[0] = (W+2)'($signed(s1_in1r_q));
    op_a[1] = (W+2)'($signed(s1_in1i_q));
    op_a[2] = op_a[0];
    op_a[3] = op_a[1];
    op_t[0] = (W+2)'(s1_tr_q);
    op_t[1] = (W+2)'(s1_ti_q);
    op_t[2] = op_t[0];
    op_t[3] = op_t[1];
    oor     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      wide[i] = (i < 2) ? (op_a[i] + op_t[i]) : (op_a[i] - op_t[i]);
      if (s1_scale_q) wide[i] = wide[i] >>> 1;
      oor[i]  = (wide[i] > MAX_V) || (wide[i] < MIN_V);
      s2_d[i] = s2_q[i];
      if (s2_upd) begin
`ifdef BUTTERFLY_PIPE_SAT_EN
        if (wide[i] > MAX_V)      s2_d[i] = W'(MAX_I);
        else if (wide[i] < MIN_V) s2_d[i] = W'(MIN_I);
        else                      s2_d[i] = W'(wide[i]);
`else
        s2_d[i] = W'(wide[i]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_scale_q <= 1'b0;
      s1_in1r_q  <= '0;
      s1_in1i_q  <= '0;
      s1_tr_q    <= '0;
      s1_ti_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_q       <= '{default: '0};
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_scale_q <= s1_scale_d;
      s1_in1r_q  <= s1_in1r_d;
      s1_in1i_q  <= s1_in1i_d;
      s1_tr_q    <= s1_tr_d;
      s1_ti_q    <= s1_ti_d;
      s2_valid_q <= s2_valid_d;
      s2_q       <= s2_d;
    end
  end

`ifdef BUTTERFLY_PIPE_SAT_EN
  logic ovf_q, ovf_d;

  // Clear wins over a same-cycle set
  always_comb begin
    ovf_d = ovf_clr ? 1'b0 : (ovf_q || (s2_upd && (|oor)));
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_src;
  assign unused_ovf_src = ^{ovf_clr, oor};
  assign ovf = 1'b0;
`endif

  assign out_valid = s2_valid_q;
  assign out_1_r   = s2_q[0];
  assign out_1_i   = s2_q[1];
  assign out_2_r   = s2_q[2];
  assign out_2_i   = s2_q[3];

endmodule

// File: tb/tb_butterfly_pipe.sv
// tb_butterfly_pipe: directed and randomized checks of butterfly_pipe against an integer-arithmetic model.
module tb_butterfly_pipe;

`ifdef BUTTERFLY_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, scale, out_valid, out_ready, ovf, ovf_clr;
  logic [1:0] tw_k;
  logic [7:0] in_1_r, in_1_i, in_2_r, in_2_i;
  logic [7:0] out_1_r, out_1_i, out_2_r, out_2_i;

  always #5 clk = ~clk;

  butterfly_pipe #(.N(3), .RECIP(181)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .tw_k(tw_k), .scale(scale),
    .in_1_r(in_1_r), .in_1_i(in_1_i), .in_2_r(in_2_r), .in_2_i(in_2_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_1_r(out_1_r), .out_1_i(out_1_i), .out_2_r(out_2_r), .out_2_i(out_2_i),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [31:0] d;
    bit          oor;
    int          t;
  } item_t;

  item_t q[$];
  int    nvec = 0, nmis = 0, cyc = 0, npop = 0;
  bit    ovf_any = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {a[7:0], b[7:0], c[7:0], d[7:0]};
  endfunction

  function automatic int fdiv(input int a, input int b);
    int r;
    r = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) r = r - 1;
    return r;
  endfunction

  function automatic int rq(input int x);
    return fdiv(x * 181, 256);
  endfunction

  function automatic item_t model(input int k, input bit sc, input int ar, input int ai,
                                  input int br, input int bi);
    int    tr, ti;
    int    v[4];
    item_t it;
    case (k)
      0:       begin tr = br;           ti = bi;            end
      1:       begin tr = rq(br + bi);  ti = rq(bi - br);   end
      2:       begin tr = bi;           ti = -br;           end
      default: begin tr = rq(bi - br);  ti = rq(-(br + bi)); end
    endcase
    v[0] = ar + tr; v[1] = ai + ti; v[2] = ar - tr; v[3] = ai - ti;
    it.oor = 1'b0;
    it.t   = 0;
    for (int i = 0; i < 4; i++) begin
      if (sc) v[i] = fdiv(v[i], 2);
      if (v[i] > 127 || v[i] < -128) it.oor = 1'b1;
      if (SAT) v[i] = (v[i] > 127) ? 127 : ((v[i] < -128) ? -128 : v[i]);
    end
    it.d = pk(v[0], v[1], v[2], v[3]);
    return it;
  endfunction

  // One cycle: drive at the falling edge, score what the next rising edge will see.
  task automatic step(input bit r, input bit iv, input int k, input bit sc,
                      input int ar, input int ai, input int br, input int bi,
                      input bit ordy, input bit clr, output bit acc);
    item_t it;
    @(negedge clk);
    rst = r; in_valid = iv; tw_k = 2'(k); scale = sc;
    in_1_r = 8'(ar); in_1_i = 8'(ai); in_2_r = 8'(br); in_2_i = 8'(bi);
    out_ready = ordy; ovf_clr = clr;
    #1;
    acc = 1'b0;
    if (clr) ovf_any = 1'b0;
    if (r) begin
      check("in_ready_in_rst", 32'(in_ready), 32'(0));
      q.delete();
      ovf_any = 1'b0;
    end else begin
      check("in_ready", 32'(in_ready), 32'((q.size() < 2) || ordy));
      check("out_valid", 32'(out_valid), 32'((q.size() > 0) && (cyc - q[0].t >= 2)));
      if (out_valid && q.size() > 0)
        check("out_data", {out_1_r, out_1_i, out_2_r, out_2_i}, q[0].d);
      if (out_valid && ordy && q.size() > 0) begin
        void'(q.pop_front());
        npop++;
      end
      if (iv && in_ready) begin
        it   = model(k, sc, ar, ai, br, bi);
        it.t = cyc;
        q.push_back(it);
        ovf_any = ovf_any | it.oor;
        acc = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic idle(input bit clr);
    bit acc;
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b1, clr, acc);
  endtask

  task automatic push(input int k, input bit sc, input int ar, input int ai,
                      input int br, input int bi);
    bit acc;
    step(1'b0, 1'b1, k, sc, ar, ai, br, bi, 1'b1, 1'b0, acc);
    check("push_accept", 32'(acc), 32'(1));
  endtask

  task automatic check_reset_state();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", {out_1_r, out_1_i, out_2_r, out_2_i}, 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int i, stalls, start;
    rst = 1'b1; in_valid = 1'b0; tw_k = '0; scale = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    in_1_r = '0; in_1_i = '0; in_2_r = '0; in_2_i = '0;

    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, acc);
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, acc);
    idle(1'b0);
    check_reset_state();

    push(0, 1'b1, 20, 10, 6, -4);
    idle(1'b0); idle(1'b0);
    check("t1_k0_scale", {out_1_r, out_1_i, out_2_r, out_2_i}, pk(13, 3, 7, 7));

    push(1, 1'b0, 0, 0, 64, 0);
    idle(1'b0); idle(1'b0);
    check("t2_k1", {out_1_r, out_1_i, out_2_r, out_2_i}, pk(45, -46, -45, 46));

    push(2, 1'b0, 100, 100, 10, 20);
    push(3, 1'b0, 100, 100, 10, 20);
    idle(1'b0);
    check("t3_k2", {out_1_r, out_1_i, out_2_r, out_2_i}, pk(120, 90, 80, 110));
    idle(1'b0);
    check("t3_k3", {out_1_r, out_1_i, out_2_r, out_2_i}, pk(107, 78, 93, 122));

    push(0, 1'b0, 100, 0, 100, 0);
    idle(1'b0); idle(1'b0);
    check("t4_range", {out_1_r, out_1_i, out_2_r, out_2_i},
          SAT ? pk(127, 0, 0, 0) : pk(-56, 0, 0, 0));
    check("t4_ovf_set", 32'(ovf), 32'(SAT));
    idle(1'b1);
    idle(1'b0);
    check("t4_ovf_clr", 32'(ovf), 32'(0));

    // Overflowing load lands on the same edge as ovf_clr
    step(1'b0, 1'b1, 0, 1'b0, 100, 0, 100, 0, 1'b1, 1'b1, acc);
    idle(1'b1);
    idle(1'b0);
    check("ovf_clr_priority", 32'(ovf), 32'(0));
    idle(1'b0);

    start = npop; i = 0; stalls = 0;
    for (int j = 0; j < 40 && npop < start + 6; j++) begin
      step(1'b0, i < 6, i % 4, 1'b0, 10 * i, -3 * i, i, 2 * i, !(j >= 2 && j < 5), 1'b0, acc);
      if (i < 6 && !acc) stalls++;
      if (acc) i++;
    end
    check("t5_emerged", 32'(npop - start), 32'(6));
    check("t5_accepted", 32'(i), 32'(6));
    check("t5_stall_cycles", 32'(stalls), 32'(3));

    push(1, 1'b0, 5, 6, 7, 8);
    push(3, 1'b1, -9, 11, -50, 33);
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, acc);
    idle(1'b0);
    check_reset_state();
    push(0, 1'b1, 20, 10, 6, -4);
    idle(1'b0); idle(1'b0);
    check("t6_after_rst", {out_1_r, out_1_i, out_2_r, out_2_i}, pk(13, 3, 7, 7));

    idle(1'b1);
    for (int j = 0; j < 400; j++) begin
      step(1'b0, $urandom_range(0, 9) < 7, int'($urandom_range(0, 3)), 1'(($urandom_range(0, 1))),
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 9) < 7, 1'b0, acc);
    end
    for (int j = 0; j < 20 && q.size() > 0; j++) idle(1'b0);
    check("drain_empty", 32'(q.size()), 32'(0));
    check("ovf_sticky", 32'(ovf), 32'(SAT ? ovf_any : 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
